// File: rtl/somador_serial_ctrl.sv
// Bit-serial sequencer around one dual-rail (NULL convention) full adder.
// Optional phase timeout: define SOMADOR_TIMEOUT_EN to enable it.
module somador_serial_ctrl #(
    parameter int WIDTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             err,
    output logic             fa_a_t,
    output logic             fa_a_f,
    output logic             fa_b_t,
    output logic             fa_b_f,
    output logic             fa_cin_t,
    output logic             fa_cin_f,
    input  logic             fa_soma_t,
    input  logic             fa_soma_f,
    input  logic             fa_cout_t,
    input  logic             fa_cout_f
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL,
        S_FIN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    nxt;
    logic             carry;
    logic             data_ok;
    logic             null_ok;

    // A DATA wavefront of value x is t=x, f=~x; never 11.
    function automatic logic [5:0] dr(input logic a, input logic b, input logic c);
        return {a, ~a, b, ~b, c, ~c};
    endfunction

    assign nxt     = idx + 1'b1;
    assign data_ok = (fa_soma_t ^ fa_soma_f) & (fa_cout_t ^ fa_cout_f);
    assign null_ok = ~(fa_soma_t | fa_soma_f | fa_cout_t | fa_cout_f);

`ifdef SOMADOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;
    logic          in_phase;
    logic          phase_ok;

    assign in_phase = (state == S_DATA) || (state == S_NULL);
    assign phase_ok = (state == S_DATA) ? data_ok : null_ok;
`else
    assign err = 1'b0;
`endif

    // Sequencer: one DATA then one NULL wavefront per bit, all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f} <= 6'b0;
`ifdef SOMADOR_TIMEOUT_EN
            cnt    <= '0;
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        carry <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f}
                            <= dr(op_a[0], op_b[0], cin);
                        state <= S_DATA;
`ifdef SOMADOR_TIMEOUT_EN
                        cnt   <= '0;
                        err   <= 1'b0;
`endif
                    end
                end
                S_DATA: begin
                    if (data_ok) begin
                        result[idx] <= fa_soma_t;
                        carry       <= fa_cout_t;
                        {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f} <= 6'b0;
                        state       <= S_NULL;
`ifdef SOMADOR_TIMEOUT_EN
                        cnt         <= '0;
`endif
                    end
                end
                S_NULL: begin
                    if (null_ok) begin
                        if (idx == LAST) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= nxt;
                            {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f}
                                <= dr(a_q[nxt], b_q[nxt], carry);
                            state <= S_DATA;
`ifdef SOMADOR_TIMEOUT_EN
                            cnt   <= '0;
`endif
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cout  <= carry;
                    state <= S_IDLE;
                end
            endcase
`ifdef SOMADOR_TIMEOUT_EN
            // A stalled phase abandons the operation; the later assignments win.
            if (in_phase && !phase_ok) begin
                if (cnt == LIM) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    err   <= 1'b1;
                    {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f} <= 6'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Self-checking bench for somador_serial_ctrl (WIDTH=4) with a
// behavioural dual-rail full adder whose response delay is adjustable.
module tb_somador_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op_a = '0;
    logic [3:0] op_b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, err;
    logic [3:0] result;
    logic       fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f;
    logic       fa_soma_t, fa_soma_f, fa_cout_t, fa_cout_f;

    int tests = 0;
    int fails = 0;
    int mon_bad = 0;
    int dly = 0;
    bit stuck = 1'b0;

    always #5 clk = ~clk;

    somador_serial_ctrl #(.WIDTH(4), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .err(err),
        .fa_a_t(fa_a_t), .fa_a_f(fa_a_f), .fa_b_t(fa_b_t), .fa_b_f(fa_b_f),
        .fa_cin_t(fa_cin_t), .fa_cin_f(fa_cin_f),
        .fa_soma_t(fa_soma_t), .fa_soma_f(fa_soma_f),
        .fa_cout_t(fa_cout_t), .fa_cout_f(fa_cout_f)
    );

    // Behavioural adder: all-NULL inputs give NULL outputs, else the arithmetic sum.
    logic [5:0] rails;
    logic [3:0] tgt;
    logic [3:0] pipe [0:7];
    logic [3:0] fa_out;
    logic [1:0] s2;

    assign rails = {fa_a_t, fa_a_f, fa_b_t, fa_b_f, fa_cin_t, fa_cin_f};

    always_comb begin
        tgt = 4'b0;
        s2  = 2'b0;
        if (rails != 6'b0) begin
            s2  = 2'(fa_a_t) + 2'(fa_b_t) + 2'(fa_cin_t);
            tgt = {s2[0], ~s2[0], s2[1], ~s2[1]};
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) pipe[k] <= 4'b0;
        end else begin
            pipe[0] <= tgt;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
    end

    always_comb begin
        fa_out = (dly == 0) ? tgt : pipe[dly-1];
        if (stuck) fa_out[3:2] = 2'b00;
    end

    assign {fa_soma_t, fa_soma_f, fa_cout_t, fa_cout_f} = fa_out;

    // Rail monitor: never 11, and two different DATA wavefronts always have NULL between them.
    logic [5:0] prev_rails = 6'b0;
    always @(negedge clk) begin
        if ((fa_a_t & fa_a_f) | (fa_b_t & fa_b_f) | (fa_cin_t & fa_cin_f)) begin
            mon_bad++;
            $display("FAIL rail_11: rails=%b", rails);
        end
        if (prev_rails != 6'b0 && rails != 6'b0 && rails != prev_rails) begin
            mon_bad++;
            $display("FAIL rail_no_null: prev=%b now=%b", prev_rails, rails);
        end
        prev_rails <= rails;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                         output logic [3:0] r, output logic co,
                         output int lat, output logic bz);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bz  = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        co = cout;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        int         d;
        logic [3:0] er;
        logic       ec;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [3:0] r;
        logic       co;
        logic       bz;
        int         lat;
        int         nd;
        logic [4:0] ref_sum;

        tbl[0] = '{4'h3, 4'h5, 1'b0, 0, 4'h8, 1'b0};
        tbl[1] = '{4'hF, 4'h1, 1'b0, 0, 4'h0, 1'b1};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 0, 4'hF, 1'b1};
        tbl[3] = '{4'h0, 4'h0, 1'b1, 3, 4'h1, 1'b0};
        tbl[4] = '{4'h7, 4'h7, 1'b0, 0, 4'hE, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_rails", rails, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 5; i++) begin
            dly = tbl[i].d;
            do_op(tbl[i].a, tbl[i].b, tbl[i].c, r, co, lat, bz);
            chk($sformatf("tbl%0d_busy", i), bz, 1);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].er);
            chk($sformatf("tbl%0d_cout", i), co, tbl[i].ec);
            chk($sformatf("tbl%0d_latency", i), lat, 2 * 4 * (tbl[i].d + 1) + 1);
            chk($sformatf("tbl%0d_busy_at_done", i), busy, 0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_done_pulse", i), done, 0);
        end
        dly = 0;

        // Second start while busy is ignored
        @(negedge clk);
        op_a = 4'h1; op_b = 4'h1; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) begin
                op_a = 4'h2; op_b = 4'h2; start = 1'b1;
            end
            if (cyc == 4) start = 1'b0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                nd++;
                r = result;
            end
        end
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_result", r, 4'h2);
        chk("busy_start_idle", busy, 0);

        // Reset during DATA of bit 2
        @(negedge clk);
        op_a = 4'h5; op_b = 4'h6; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_data", (rails != 6'b0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rails", rails, 0);
        chk("mid_rst_busy", busy, 0);
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) nd++;
        end
        chk("mid_rst_no_done", nd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'h7, 4'h7, 1'b0, r, co, lat, bz);
        chk("after_rst_result", r, 4'hE);
        chk("after_rst_cout", co, 0);

        // Adder Soma stuck at NULL
        stuck = 1'b1;
        @(negedge clk);
        op_a = 4'h3; op_b = 4'h1; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        chk("stuck_no_done", nd, 0);
`ifdef SOMADOR_TIMEOUT_EN
        chk("stuck_err", err, 1);
        chk("stuck_busy", busy, 0);
        chk("stuck_rails", rails, 0);
`else
        chk("stuck_err", err, 0);
        chk("stuck_busy", busy, 1);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised operations against plain arithmetic
        for (int i = 0; i < 16; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            rc  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            ref_sum = 5'(ra) + 5'(rb) + 5'(rc);
            do_op(ra, rb, rc, r, co, lat, bz);
            chk($sformatf("rnd%0d_result", i), r, ref_sum[3:0]);
            chk($sformatf("rnd%0d_cout", i), co, ref_sum[4]);
            chk($sformatf("rnd%0d_latency", i), lat, 2 * 4 * (dly + 1) + 1);
        end
        dly = 0;

        repeat (2) @(posedge clk);
        chk("rail_monitor", mon_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
